// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for an 8-digit common-anode seven-segment
//   display. One shared segment bus is driven while the anodes are sequenced
//   digit by digit. Each digit slot lasts SCAN_DIV cycles. The first BLANK_CYC
//   cycles of a slot keep every anode off so the previous digit cannot ghost
//   into the next one.
//
//   The displayed value is double-buffered. load_i captures into a staging
//   register, and staging is committed to the active register only at the end
//   of the digit-7 slot, so a frame never shows a mix of old and new data.
//
//   Optional build macro:
//     SEG_SCAN_LEAD_ZERO_BLANK_EN - darken leading-zero digits (digit 0 is
//                                   never darkened by this rule).
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   en_i        scan enable; low = display dark, scan counters frozen
//   data_i      8 hex nibbles, nibble k drives digit k
//   dp_i        decimal point per digit, 1 = lit
//   load_i      1-cycle strobe, captures data_i/dp_i into staging
//   dig_en_i    live per-digit enable, 1 = digit may light
//   disp_seg_o  active-low segments, bit7 = dp, bits6..0 = gfedcba
//   disp_an_o   active-low anodes, bit k = digit k
//   upd_pend_o  staging holds data not yet committed
//   frame_o     1-cycle pulse after the end of the digit-7 slot
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int SCAN_DIV  = 100000,
   parameter int BLANK_CYC = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_i,
   input  logic [31:0] data_i,
   input  logic [7:0]  dp_i,
   input  logic        load_i,
   input  logic [7:0]  dig_en_i,
   output logic [7:0]  disp_seg_o,
   output logic [7:0]  disp_an_o,
   output logic        upd_pend_o,
   output logic        frame_o
);

   localparam int             PW     = $clog2(SCAN_DIV);
   localparam logic [PW-1:0]  P_LAST = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0]  P_BLNK = PW'(BLANK_CYC);

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic [PW-1:0] presc_nx;
   logic [2:0]    idx;
   logic [31:0]   staging;
   logic [7:0]    staging_dp;
   logic [31:0]   active;
   logic [7:0]    active_dp;
   logic [3:0]    cur_nib;
   logic          cur_dark;

   // Active-low gfedcba pattern for one hex nibble.
   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign presc_nx = presc + PW'(1);
   assign cur_nib  = active[{idx, 2'b00} +: 4];

   // A digit is dark in SHOW when its live enable is off or, with leading-zero
   // blanking, when it and every higher nibble are zero.
   always_comb begin
      cur_dark = ~dig_en_i[idx];
`ifdef SEG_SCAN_LEAD_ZERO_BLANK_EN
      if ((idx != 3'd0) && ((active >> {idx, 2'b00}) == 32'd0))
         cur_dark = 1'b1;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_BLANK;
         presc      <= '0;
         idx        <= 3'd0;
         staging    <= '0;
         staging_dp <= '0;
         active     <= '0;
         active_dp  <= '0;
         upd_pend_o <= 1'b0;
         frame_o    <= 1'b0;
         disp_seg_o <= 8'hFF;
         disp_an_o  <= 8'hFF;
      end else begin
         frame_o <= 1'b0;

         if (load_i) begin
            staging    <= data_i;
            staging_dp <= dp_i;
            upd_pend_o <= 1'b1;
         end

         // Scan counters: advance only while enabled.
         if (en_i) begin
            if (presc == P_LAST) begin
               presc <= '0;
               idx   <= idx + 3'd1;
               state <= ST_BLANK;
               if (idx == 3'd7) begin
                  frame_o <= 1'b1;
                  // Active takes the pre-edge staging; a same-cycle load keeps
                  // the pending flag set for the following frame.
                  if (upd_pend_o) begin
                     active    <= staging;
                     active_dp <= staging_dp;
                     if (!load_i)
                        upd_pend_o <= 1'b0;
                  end
               end
            end else begin
               presc <= presc_nx;
               if (presc_nx == P_BLNK)
                  state <= ST_SHOW;
            end
         end

         // Output register stage, one cycle behind presc/state/idx.
         if (!en_i || (state == ST_BLANK) || cur_dark) begin
            disp_an_o  <= 8'hFF;
            disp_seg_o <= 8'hFF;
         end else begin
            disp_an_o  <= ~(8'b1 << idx);
            disp_seg_o <= {~active_dp[idx], seg_decode(cur_nib)};
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Self-checking bench for seg_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2.
//   The reference model tracks time as a count of enabled cycles since reset
//   and derives slot, digit and frame position arithmetically from it.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

   localparam int SD = 8;
   localparam int BC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_i;
   logic [31:0] data_i;
   logic [7:0]  dp_i;
   logic        load_i;
   logic [7:0]  dig_en_i;
   logic [7:0]  disp_seg_o;
   logic [7:0]  disp_an_o;
   logic        upd_pend_o;
   logic        frame_o;

   seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en_i),
      .data_i     (data_i),
      .dp_i       (dp_i),
      .load_i     (load_i),
      .dig_en_i   (dig_en_i),
      .disp_seg_o (disp_seg_o),
      .disp_an_o  (disp_an_o),
      .upd_pend_o (upd_pend_o),
      .frame_o    (frame_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state
   int          m_tick;
   logic [31:0] m_stg, m_act;
   logic [7:0]  m_sdp, m_adp;
   logic        m_pend;
   logic        m_lz;
   logic [7:0]  tbl [16];

   // Coverage-ish counters for the dig_en_i=05 phase
   int lit_other;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic step(input logic r, input logic e, input logic ld,
                       input logic [31:0] d, input logic [7:0] dp, input logic [7:0] de);
      logic [7:0] e_an, e_seg;
      logic       e_frm;
      int         pos, sl;
      logic [3:0] nib;
      logic       dark;
      rst = r; en_i = e; load_i = ld; data_i = d; dp_i = dp; dig_en_i = de;
      @(posedge clk);
      e_an = 8'hFF; e_seg = 8'hFF; e_frm = 1'b0;
      if (r) begin
         m_tick = 0; m_stg = '0; m_act = '0; m_sdp = '0; m_adp = '0; m_pend = 1'b0;
      end else begin
         if (e) begin
            pos  = m_tick % SD;
            sl   = (m_tick / SD) % 8;
            nib  = 4'(m_act >> (4 * sl));
            dark = !de[sl] || (m_lz && sl > 0 && (m_act >> (4 * sl)) == 0);
            if (pos >= BC && !dark) begin
               e_an  = ~(8'h01 << sl);
               e_seg = {~m_adp[sl], tbl[nib][6:0]};
            end
            if (pos == SD - 1 && sl == 7) begin
               e_frm = 1'b1;
               if (m_pend) begin
                  m_act = m_stg; m_adp = m_sdp; m_pend = 1'b0;
               end
            end
            m_tick++;
         end
         if (ld) begin
            m_stg = d; m_sdp = dp; m_pend = 1'b1;
         end
      end
      #1;
      chk("an",   {24'd0, disp_an_o},  {24'd0, e_an});
      chk("seg",  {24'd0, disp_seg_o}, {24'd0, e_seg});
      chk("pend", {31'd0, upd_pend_o}, {31'd0, m_pend});
      chk("frm",  {31'd0, frame_o},    {31'd0, e_frm});
      if (e_an != 8'hFF && e_an != 8'hFE && e_an != 8'hFB) lit_other++;
   endtask

   task automatic idle(input int n, input logic [7:0] de);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 32'd0, 8'd0, de);
   endtask

   initial begin
      tbl[0]  = 8'hC0; tbl[1]  = 8'hF9; tbl[2]  = 8'hA4; tbl[3]  = 8'hB0;
      tbl[4]  = 8'h99; tbl[5]  = 8'h92; tbl[6]  = 8'h82; tbl[7]  = 8'hF8;
      tbl[8]  = 8'h80; tbl[9]  = 8'h90; tbl[10] = 8'h88; tbl[11] = 8'h83;
      tbl[12] = 8'hC6; tbl[13] = 8'hA1; tbl[14] = 8'h86; tbl[15] = 8'h8E;
`ifdef SEG_SCAN_LEAD_ZERO_BLANK_EN
      m_lz = 1'b1;
`else
      m_lz = 1'b0;
`endif
      m_tick = 0; m_stg = '0; m_act = '0; m_sdp = '0; m_adp = '0; m_pend = 1'b0;
      lit_other = 0;

      // Reset, with a load pending in the same cycles (must be discarded)
      step(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 8'hFF, 8'hFF);
      step(1'b1, 1'b0, 1'b0, 32'd0, 8'd0, 8'hFF);

      // Free-running scan of zeros, two frames
      idle(130, 8'hFF);

      // Mid-frame load, then past the commit
      idle(13, 8'hFF);
      step(1'b0, 1'b1, 1'b1, 32'h89ABCDEF, 8'h01, 8'hFF);
      idle(140, 8'hFF);

      // Load exactly on the commit cycle
      step(1'b0, 1'b1, 1'b1, 32'h01234567, 8'h80, 8'hFF);
      for (int b = 0; b < 200 && (m_tick % 64) != 63; b++) idle(1, 8'hFF);
      chk("commit_align", m_tick % 64, 63);
      step(1'b0, 1'b1, 1'b1, 32'h76543210, 8'h3C, 8'hFF);
      idle(140, 8'hFF);

      // Only digits 0 and 2 enabled
      lit_other = 0;
      idle(70, 8'h05);
      chk("dig05_other_lit", lit_other, 0);

      // Freeze mid-SHOW for 20 cycles, resume
      for (int b = 0; b < 20 && (m_tick % SD) != 4; b++) idle(1, 8'hFF);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, (i == 7), 32'hA5A50F0F, 8'h55, 8'hFF);
      idle(30, 8'hFF);

      // Reset pulse mid-slot
      idle(3, 8'hFF);
      step(1'b1, 1'b1, 1'b0, 32'd0, 8'd0, 8'hFF);
      idle(20, 8'hFF);

      // Leading-zero pattern
      step(1'b0, 1'b1, 1'b1, 32'h00000305, 8'h00, 8'hFF);
      idle(200, 8'hFF);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] d;
         logic        ld, e;
         d = $urandom();
         if ($urandom_range(0, 3) == 0) d = d & (32'hFFFFFFFF >> (4 * $urandom_range(1, 7)));
         ld = ($urandom_range(0, 39) == 0);
         e  = ($urandom_range(0, 15) != 0);
         step(($urandom_range(0, 999) == 0), e, ld, d, 8'($urandom()),
              ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'hFF);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 8-digit common-anode seven-segment display.
- Shares the single disp_seg_o bus among 8 digits by sequencing disp_an_o.
- Double-buffers the displayed value so updates never tear mid-frame.
- Inserts a blanking interval between digits against ghosting.
- Replaces single-digit drivers; counter and FSM blocks feed it 8 hex nibbles.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); must be >= BLANK_CYC+2.
BLANK_CYC, 1000, cycles at the start of each slot with all anodes off; must be >= 1.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
en_i  input  1  scan enable; low = display dark, counters frozen
data_i  input  32  8 hex nibbles; nibble k = data_i[4k+3:4k] drives digit k
dp_i  input  8  decimal point per digit, 1 = lit
load_i  input  1  1-cycle strobe: capture data_i/dp_i into staging
dig_en_i  input  8  live per-digit enable, 1 = digit may light
disp_seg_o  output  8  active-low, bit7 = dp, bits6..0 = gfedcba
disp_an_o  output  8  active-low anodes, bit k = digit k
upd_pend_o  output  1  staging holds data not yet committed
frame_o  output  1  1-cycle pulse at end of digit-7 slot

Behaviour:
- Reset (clk edge with rst=1): disp_seg_o=8'hFF, disp_an_o=8'hFF, upd_pend_o=0, frame_o=0. Prescaler=0, digit index=0, state=BLANK. Staging and active registers are cleared to 0. rst overrides all other inputs. A pending load is discarded.
- Prescaler counts 0..SCAN_DIV-1 while en_i=1. On SCAN_DIV-1 it wraps to 0 and the index advances idx=(idx+1) mod 8.
- FSM with two states:
  - BLANK while prescaler<BLANK_CYC.
  - SHOW otherwise.
  - BLANK->SHOW at prescaler==BLANK_CYC.
  - SHOW->BLANK at wrap.
- All outputs are registered, with 1-cycle latency from prescaler/state/index.
- BLANK: disp_an_o=8'hFF, disp_seg_o=8'hFF.
- SHOW, digit enabled: when dig_en_i[idx]=1, disp_an_o=~(8'b1<<idx). disp_seg_o[6:0]=decode(active nibble idx) and disp_seg_o[7]=~active_dp[idx].
- SHOW, digit disabled: when dig_en_i[idx]=0, both outputs are 8'hFF. dig_en_i is sampled live.
- Decode table (bit7=1 shown): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- load_i=1 (en_i irrelevant): staging<=data_i, staging_dp<=dp_i, upd_pend_o<=1. A later load before commit overwrites the earlier one.
- Commit happens on the wrap cycle with idx==7: frame_o=1 for one cycle; if upd_pend_o=1, active<=staging and upd_pend_o<=0.
- Commit and load in the same cycle: active takes the old staging. Staging takes data_i, and upd_pend_o stays 1 for the next frame.
- en_i=0: prescaler, index and FSM hold. Outputs go to 8'hFF on the next edge, and frame_o=0. Loads are still accepted. On en_i rising, scan resumes from the held prescaler/index.

Optional Feature:
- Macro: SEG_SCAN_LEAD_ZERO_BLANK_EN.
- Defined: during SHOW, digit k>0 is forced dark (an bit=1, seg=8'hFF) when active nibbles k..7 are all 0. Digit 0 is always shown if enabled. The dp does not prevent blanking.
- Undefined: every enabled digit shows its nibble, including leading zeros.

Test Plan (SCAN_DIV=8, BLANK_CYC=2):
- Reset, en_i=1, dig_en_i=FF, no load -> per slot: 2 cycles an=FF, then 6 cycles an=FE/FD/.../7F in turn with seg=C0. frame_o pulses every 64 cycles.
- load_i with data_i=32'h89ABCDEF, dp_i=8'h01 mid-frame -> upd_pend_o=1 until the next digit-7 wrap. The following frame shows digit0 seg=0E (F with dp), digit7 seg=80, and upd_pend_o=0.
- load_i exactly on the commit cycle -> the old staging is displayed and upd_pend_o stays 1. The new value appears one frame later.
- dig_en_i=8'h05 -> only an=FE and an=FB are ever driven low. The other slots stay all FF with timing unchanged.
- en_i low for 20 cycles mid-SHOW, then rst pulse mid-slot -> outputs FF while frozen and the scan resumes at the same index. rst forces FF, idx 0, and upd_pend_o=0 on the next edge.
- With SEG_SCAN_LEAD_ZERO_BLANK_EN, data 32'h00000305 -> only digits 0..2 light (92, C0, B0). Without the macro, digits 3..7 show C0.
